// File: rtl/pswd_attempt_ctrl.sv
// rtl/pswd_attempt_ctrl.sv - password-entry attempt sequencer with failure lockout
//
// Purpose:
//   Gates start/end button pulses toward the password FSM, waits for its
//   verdict, counts consecutive failures and enforces a timed lockout.
//
// Ports:
//   i_clk            system clock
//   i_rst            asynchronous active-high reset
//   i_start_pulse    one-cycle start pulse from the edge detector
//   i_end_pulse      one-cycle end pulse from the edge detector
//   i_verdict_valid  one-cycle strobe: comparison complete
//   i_verdict_ok     password matched (qualified by i_verdict_valid)
//   o_start_gated    forwarded start pulse (1-cycle latency)
//   o_end_gated      forwarded end pulse (1-cycle latency)
//   o_locked         high while LOCKED
//   o_unlocked       high while UNLOCKED
//   o_fails_left     MAX_FAIL minus the consecutive failure count
//   o_lock_remain    lockout seconds remaining (0 outside LOCKED)
//   o_disp_blank     7-segment blank request
//   o_ctrl_state     state code: IDLE=0 ENTRY=1 WAIT=2 UNLOCKED=3 LOCKED=4
//
// Optional feature macro: LOCK_BLINK_EN (blink displays at 1 Hz while LOCKED).

module pswd_attempt_ctrl #(
  parameter int CLK_HZ     = 50000000,
  parameter int MAX_FAIL   = 3,
  parameter int LOCK_SEC   = 30,
  parameter int VERDICT_TO = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start_pulse,
  input  logic       i_end_pulse,
  input  logic       i_verdict_valid,
  input  logic       i_verdict_ok,
  output logic       o_start_gated,
  output logic       o_end_gated,
  output logic       o_locked,
  output logic       o_unlocked,
  output logic [3:0] o_fails_left,
  output logic [7:0] o_lock_remain,
  output logic       o_disp_blank,
  output logic [2:0] o_ctrl_state
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ENTRY    = 3'd1,
    S_WAIT     = 3'd2,
    S_UNLOCKED = 3'd3,
    S_LOCKED   = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_fail_cnt, w_fail_nxt;
  logic [PW-1:0]   r_presc, w_presc_nxt;
  logic [7:0]      r_to_cnt, w_to_nxt;
  logic [7:0]      r_lock_remain, w_lock_nxt;
  logic            w_start_acc, w_end_acc;
  logic            w_blank_nxt;
  logic            r_start_gated, r_end_gated;
  logic            r_locked, r_unlocked;
  logic [3:0]      r_fails_left;
  logic            r_disp_blank;

`ifdef LOCK_BLINK_EN
  localparam int HALF = (CLK_HZ / 2 < 1) ? 1 : CLK_HZ / 2;
  localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
  logic [HW-1:0]   r_half_cnt, w_half_nxt;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_fail_nxt  = r_fail_cnt;
    w_presc_nxt = r_presc;
    w_to_nxt    = r_to_cnt;
    w_lock_nxt  = r_lock_remain;
    w_start_acc = 1'b0;
    w_end_acc   = 1'b0;
    w_blank_nxt = 1'b0;
`ifdef LOCK_BLINK_EN
    w_half_nxt  = '0;
`endif
    case (r_state)
      S_IDLE, S_UNLOCKED: begin
        // start takes precedence; end pulses are dropped here
        if (i_start_pulse) begin
          w_start_acc = 1'b1;
          w_state_nxt = S_ENTRY;
        end
      end
      S_ENTRY: begin
        // end takes precedence over a coincident start
        if (i_end_pulse) begin
          w_end_acc   = 1'b1;
          w_state_nxt = S_WAIT;
          w_to_nxt    = 8'(VERDICT_TO);
        end else if (i_start_pulse) begin
          w_start_acc = 1'b1;
        end
      end
      S_WAIT: begin
        w_to_nxt = r_to_cnt - 8'd1;
        if (i_verdict_valid && i_verdict_ok) begin
          w_fail_nxt  = 4'd0;
          w_state_nxt = S_UNLOCKED;
        end else if (i_verdict_valid || (r_to_cnt == 8'd1)) begin
          // counter at 1 means this is the last cycle of the verdict window
          w_fail_nxt = r_fail_cnt + 4'd1;
          if (w_fail_nxt == 4'(MAX_FAIL)) begin
            w_state_nxt = S_LOCKED;
            w_lock_nxt  = 8'(LOCK_SEC);
            w_presc_nxt = '0;
            w_blank_nxt = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_LOCKED: begin
        if (r_lock_remain == 8'd0) begin
          w_state_nxt = S_IDLE;
          w_fail_nxt  = 4'd0;
          w_presc_nxt = '0;
        end else begin
          if (r_presc == PW'(CLK_HZ - 1)) begin
            w_presc_nxt = '0;
            w_lock_nxt  = r_lock_remain - 8'd1;
          end else begin
            w_presc_nxt = r_presc + PW'(1);
          end
`ifdef LOCK_BLINK_EN
          if (r_half_cnt == HW'(HALF - 1)) begin
            w_half_nxt  = '0;
            w_blank_nxt = ~r_disp_blank;
          end else begin
            w_half_nxt  = r_half_cnt + HW'(1);
            w_blank_nxt = r_disp_blank;
          end
`else
          w_blank_nxt = 1'b1;
`endif
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_fail_cnt    <= 4'd0;
      r_presc       <= '0;
      r_to_cnt      <= 8'd0;
      r_lock_remain <= 8'd0;
      r_start_gated <= 1'b0;
      r_end_gated   <= 1'b0;
      r_locked      <= 1'b0;
      r_unlocked    <= 1'b0;
      r_fails_left  <= 4'(MAX_FAIL);
      r_disp_blank  <= 1'b0;
`ifdef LOCK_BLINK_EN
      r_half_cnt    <= '0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_fail_cnt    <= w_fail_nxt;
      r_presc       <= w_presc_nxt;
      r_to_cnt      <= w_to_nxt;
      r_lock_remain <= w_lock_nxt;
      r_start_gated <= w_start_acc;
      r_end_gated   <= w_end_acc;
      r_locked      <= (w_state_nxt == S_LOCKED);
      r_unlocked    <= (w_state_nxt == S_UNLOCKED);
      // fail count never exceeds MAX_FAIL, so this reaches 0 exactly on lockout
      r_fails_left  <= 4'(MAX_FAIL) - w_fail_nxt;
      r_disp_blank  <= w_blank_nxt;
`ifdef LOCK_BLINK_EN
      r_half_cnt    <= w_half_nxt;
`endif
    end
  end

  assign o_start_gated = r_start_gated;
  assign o_end_gated   = r_end_gated;
  assign o_locked      = r_locked;
  assign o_unlocked    = r_unlocked;
  assign o_fails_left  = r_fails_left;
  assign o_lock_remain = r_lock_remain;
  assign o_disp_blank  = r_disp_blank;
  assign o_ctrl_state  = r_state;

endmodule

// File: doc/pswd_attempt_ctrl.md
Name: pswd_attempt_ctrl

Overview:
- Sequences the password-entry FSM.
- Sits between the start/end edge detectors and the FSM, and gates the button pulses.
- Counts failed verdicts; after MAX_FAIL consecutive failures, enforces a timed lockout shown on LEDs and displays.
- Drives lock status, remaining attempts, lockout seconds remaining and a display-blank control for the 7-segment drivers.

Parameters:
- CLK_HZ, 50000000, clock frequency; sets the 1 s tick prescaler.
- MAX_FAIL, 3, consecutive failures before lockout; legal 1..15.
- LOCK_SEC, 30, lockout duration in seconds; legal 1..255.
- VERDICT_TO, 16, cycles to wait for a verdict after the end pulse; legal 1..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start_pulse  in  1  one-cycle pulse from the start edge detector.
- end_pulse  in  1  one-cycle pulse from the end edge detector.
- verdict_valid  in  1  one-cycle strobe from the FSM; the comparison is complete.
- verdict_ok  in  1  password matched; qualified by verdict_valid.
- start_gated  out  1  one-cycle start pulse forwarded to the FSM.
- end_gated  out  1  one-cycle end pulse forwarded to the FSM.
- locked  out  1  high while in LOCKED.
- unlocked  out  1  high while in UNLOCKED.
- fails_left  out  4  MAX_FAIL minus the failure count.
- lock_remain  out  8  lockout seconds remaining; 0 outside LOCKED.
- disp_blank  out  1  blank request for the 7-segment displays.
- ctrl_state  out  3  state code for LEDs.

Behaviour:
- All outputs are registered.
- Reset values: start_gated=0, end_gated=0, locked=0, unlocked=0, fails_left=MAX_FAIL, lock_remain=0, disp_blank=0, ctrl_state=IDLE. fail_cnt, prescaler and timeout counter reset to 0.
- Reset mid-operation, including during LOCKED, aborts immediately to the reset state; the lockout is not remembered.
- State codes: IDLE=0, ENTRY=1, WAIT=2, UNLOCKED=3, LOCKED=4.
- Gated pulses: asserted exactly one cycle, in the cycle after the accepted input pulse (1-cycle latency). Dropped pulses produce nothing.
- IDLE:
  - start_pulse -> start_gated, go to ENTRY.
  - end_pulse is dropped.
  - If start and end arrive in the same cycle, start wins and end is dropped.
- ENTRY:
  - end_pulse -> end_gated, go to WAIT, load timeout counter with VERDICT_TO.
  - start_pulse alone -> start_gated (entry restart), stay in ENTRY.
  - If start and end arrive in the same cycle, end wins and start is dropped.
- WAIT: all button pulses are dropped; timeout counter decrements each cycle.
  - verdict_valid with verdict_ok=1 -> fail_cnt=0, go to UNLOCKED.
  - verdict_valid with verdict_ok=0, or timeout counter reaching 0 with no verdict -> fail_cnt+1.
    - If the new fail_cnt equals MAX_FAIL -> go to LOCKED, lock_remain=LOCK_SEC, prescaler=0.
    - Otherwise -> go to IDLE.
  - A verdict in the same cycle the timeout expires counts as the verdict, not as a timeout.
  - verdict_valid outside WAIT is ignored.
- UNLOCKED: unlocked=1; start_pulse -> start_gated, go to ENTRY; end_pulse is dropped.
- LOCKED:
  - All button pulses are dropped.
  - Prescaler counts 0..CLK_HZ-1; on wrap, lock_remain decrements. The first decrement occurs exactly CLK_HZ cycles after entering LOCKED.
  - When lock_remain reaches 0, go to IDLE next cycle with fail_cnt=0, so fails_left=MAX_FAIL.
- fails_left is updated in the same cycle as fail_cnt; it never underflows and reads 0 while locked.
- disp_blank is 0 in every state except LOCKED.

Optional Feature:
- Macro: LOCK_BLINK_EN.
- Defined: in LOCKED, disp_blank toggles every CLK_HZ/2 cycles. It starts at 1 on LOCKED entry, giving a 1 Hz blink.
- Undefined: disp_blank is held at 1 for the whole of LOCKED; no half-second divider is synthesized.

Test Plan:
All scenarios use CLK_HZ=10, MAX_FAIL=3, LOCK_SEC=3, VERDICT_TO=4.
- Reset check: assert rst mid-LOCKED -> all outputs return to reset values while rst is high; fails_left=3, ctrl_state=0.
- Pass path: start, end, then verdict_valid=1 with ok=1 two cycles later -> start_gated and end_gated each 1 cycle at +1 latency; ctrl_state 0→1→2→3; unlocked=1; fails_left=3.
- Fail and timeout: first attempt gets verdict ok=0 -> IDLE, fails_left=2. Second attempt gets no verdict -> after 4 cycles returns to IDLE, fails_left=1.
- Lockout: third failure -> locked=1, lock_remain=3; 2 after 10 cycles, 1 after 20, 0 after 30; then IDLE with fails_left=3. start_pulse during LOCKED -> start_gated stays 0.
- Simultaneous pulses: start and end in the same cycle in IDLE -> only start_gated, state ENTRY. Same in ENTRY -> only end_gated, state WAIT.
- Blink: with LOCK_BLINK_EN defined, disp_blank toggles every 5 cycles in LOCKED. Undefined, it stays 1 for all 30 cycles. In both builds it is 0 after exit.
